// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t   : operand source select driven to the E-stage muxes
//   mem_state_t : data-memory wait FSM states
//   stage_tag_t : shadow copy of one pipeline stage's register usage
//   PC_REG_IDX  : register index of the PC
//   TAG_AW      : register address width stored in the tags
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int TAG_AW = 4;
    localparam logic [TAG_AW-1:0] PC_REG_IDX = 4'd15;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } mem_state_t;

    // ra1/ra2 only carry meaning in the E tag; M and W keep them but
    // nothing reads them there.
    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] wa3;
        logic              reg_write;
        logic              memto_reg;
        logic              mem_write;
        logic              pc_src;
        logic [TAG_AW-1:0] ra1;
        logic [TAG_AW-1:0] ra2;
    } stage_tag_t;

    localparam stage_tag_t TAG_CLEAR = '0;

    // A later stage can supply operand ra when it holds a live register
    // write to exactly that register. The PC is never forwarded.
    function automatic logic fwd_hit(input stage_tag_t t,
                                     input logic [TAG_AW-1:0] ra,
                                     input logic [TAG_AW-1:0] pc_reg);
        return t.valid & t.reg_write & (t.wa3 == ra) & (ra != pc_reg);
    endfunction

    // Saturating event counter step.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Purely combinational operand-forwarding select for the E stage.
// Ports:
//   tag_m, tag_w : shadow tags of the M and W stages
//   ra1_e, ra2_e : source registers of the instruction in E
//   fwd_a, fwd_b : SrcA / SrcB select (RF, WB result, M ALU result)
// ---------------------------------------------------------------------------
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter logic [TAG_AW-1:0] PC_REG = PC_REG_IDX
)(
    input  stage_tag_t        tag_m,
    input  stage_tag_t        tag_w,
    input  logic [TAG_AW-1:0] ra1_e,
    input  logic [TAG_AW-1:0] ra2_e,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);

    // M is checked first so the youngest producer wins when both match.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (fwd_hit(tag_m, ra1_e, PC_REG))
            fwd_a = FWD_MEM;
        else if (fwd_hit(tag_w, ra1_e, PC_REG))
            fwd_a = FWD_WB;
        if (fwd_hit(tag_m, ra2_e, PC_REG))
            fwd_b = FWD_MEM;
        else if (fwd_hit(tag_w, ra2_e, PC_REG))
            fwd_b = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for the 5-stage F/D/E/M/W pipeline.
// Tracks destination/source tags for E, M and W, and produces the stall,
// flush and forwarding controls for the pipe registers. A small FSM freezes
// the whole pipeline while data memory is busy.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   RA1D, RA2D, WA3D    : decode source/destination registers
//   regWriteD, MemtoRegD, MemWriteD, PCSrcD : decode instruction class
//   BranchTakenE        : branch taken in E
//   dmem_ready          : data memory completes its access this cycle
//   StallF/D/E/M        : hold PC, F/D, D/E, E/M
//   FlushD/E            : clear F/D, D/E
//   ForwardAE/BE        : 00 RF, 01 ResultW, 10 ALUResultM
//
// Build option HAZ_PERF_CNT_EN adds saturating counters
//   stall_cnt (load-use stalls), flush_cnt (branch flushes),
//   memwait_cnt (frozen cycles).
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = TAG_AW,
    parameter int PC_REG = 15
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] RA1D,
    input  logic [REG_AW-1:0] RA2D,
    input  logic [REG_AW-1:0] WA3D,
    input  logic              regWriteD,
    input  logic              MemtoRegD,
    input  logic              MemWriteD,
    input  logic              PCSrcD,
    input  logic              BranchTakenE,
    input  logic              dmem_ready,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       memwait_cnt
`endif
);

    localparam logic [TAG_AW-1:0] PC_IDX = TAG_AW'(PC_REG);

    stage_tag_t tag_d, tag_e, tag_m, tag_w;
    mem_state_t state, state_next;
    logic       mem_busy, freeze;
    logic       ldr_hit, ldr_stall, pc_pend, br_flush, flush_e;
    fwd_sel_t   fwd_a, fwd_b;

    // Tag for the instruction currently in decode.
    always_comb begin
        tag_d           = TAG_CLEAR;
        tag_d.valid     = 1'b1;
        tag_d.wa3       = WA3D;
        tag_d.reg_write = regWriteD;
        tag_d.memto_reg = MemtoRegD;
        tag_d.mem_write = MemWriteD;
        tag_d.pc_src    = PCSrcD;
        tag_d.ra1       = RA1D;
        tag_d.ra2       = RA2D;
    end

    // A memory op in M that is not completing this cycle.
    assign mem_busy = tag_m.valid & (tag_m.memto_reg | tag_m.mem_write) & ~dmem_ready;

    // Memory wait FSM: state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // Memory wait FSM: next state.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (mem_busy)   state_next = MWAIT;
            MWAIT:   if (dmem_ready) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Memory wait FSM: output. The cycle that detects the busy access is
    // already frozen, as is the MWAIT cycle in which memory finally answers;
    // the pipeline only moves again once the FSM is back in RUN.
    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:     freeze = mem_busy;
            MWAIT:   freeze = 1'b1;
            default: freeze = 1'b0;
        endcase
    end

    // Load in E whose result a decode source needs; the PC is excluded
    // because it is never a load-use source.
    always_comb begin
        ldr_hit = tag_e.valid & tag_e.memto_reg & tag_e.reg_write &
                  (((tag_e.wa3 == RA1D) & (RA1D != PC_IDX)) |
                   ((tag_e.wa3 == RA2D) & (RA2D != PC_IDX)));
    end

    // While frozen, load-use and branch requests are ignored; they are
    // re-evaluated from the same tags once the pipeline moves again.
    assign ldr_stall = ldr_hit & ~freeze;
    assign br_flush  = BranchTakenE & ~freeze;
    assign pc_pend   = PCSrcD | (tag_e.valid & tag_e.pc_src) | (tag_m.valid & tag_m.pc_src);
    assign flush_e   = ~freeze & (br_flush | ldr_stall);

    hazard_fwd_unit #(
        .PC_REG (PC_IDX)
    ) u_fwd (
        .tag_m  (tag_m),
        .tag_w  (tag_w),
        .ra1_e  (tag_e.ra1),
        .ra2_e  (tag_e.ra2),
        .fwd_a  (fwd_a),
        .fwd_b  (fwd_b)
    );

    // Pipe-register controls. Everything reads 0 while reset is held.
    // A taken branch discards the stalled decode instruction, so it wins
    // over the load-use hold of F/D.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!reset) begin
            StallF    = freeze | ldr_stall | pc_pend;
            StallD    = freeze | (ldr_stall & ~br_flush);
            StallE    = freeze;
            StallM    = freeze;
            FlushD    = ~freeze & (br_flush | pc_pend);
            FlushE    = flush_e;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
        end
    end

    // Shadow tag pipeline; E takes a bubble whenever D/E is cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_e <= TAG_CLEAR;
            tag_m <= TAG_CLEAR;
            tag_w <= TAG_CLEAR;
        end else if (!freeze) begin
            tag_e <= flush_e ? TAG_CLEAR : tag_d;
            tag_m <= tag_e;
            tag_w <= tag_m;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            stall_cnt   <= sat_inc(stall_cnt, ldr_stall);
            flush_cnt   <= sat_inc(flush_cnt, br_flush);
            memwait_cnt <= sat_inc(memwait_cnt, freeze);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Control outputs are observed as one
// vector {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA3D;
    logic       regWriteD, MemtoRegD, MemWriteD, PCSrcD;
    logic       BranchTakenE, dmem_ready;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

    int total;
    int bad;
    logic [9:0] exp;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .WA3D         (WA3D),
        .regWriteD    (regWriteD),
        .MemtoRegD    (MemtoRegD),
        .MemWriteD    (MemWriteD),
        .PCSrcD       (PCSrcD),
        .BranchTakenE (BranchTakenE),
        .dmem_ready   (dmem_ready),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .memwait_cnt  (memwait_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE};
    endfunction

    // Drive the decode-stage inputs for the current cycle.
    task automatic applyStimulus(input logic [3:0] ra1, input logic [3:0] ra2,
                                 input logic [3:0] wa3, input logic rw,
                                 input logic m2r, input logic mw, input logic pcs,
                                 input logic br, input logic rdy);
        RA1D         = ra1;
        RA2D         = ra2;
        WA3D         = wa3;
        regWriteD    = rw;
        MemtoRegD    = m2r;
        MemWriteD    = mw;
        PCSrcD       = pcs;
        BranchTakenE = br;
        dmem_ready   = rdy;
    endtask

    // Advance one cycle; returns 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push three non-writing instructions so E, M and W hold nothing live.
    task automatic drain();
        repeat (3) begin
            applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(4'd1, 4'd1, 4'd1, 1, 1, 1, 1, 1, 0);
        #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL rst_active: got %b want %b", ctl(), exp); end
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
        #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL after_rst: got %b want %b", ctl(), exp); end
`ifdef HAZ_PERF_CNT_EN
        total++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== 96'd0) begin
            bad++; $display("[TB] FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_forwarding();
        // ADD r1 ; ADD r2,r1,r3 -> M forward
        drain();
        applyStimulus(4'd2, 4'd3, 4'd1, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd1, 4'd3, 4'd2, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_10_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL fwd_mem: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL fwd_clear: got %b want %b", ctl(), exp); end
        tick();
        // ADD r1 ; ADD r6,r7,r8 ; ADD r2,r1,r1 -> W forward on both
        drain();
        applyStimulus(4'd2, 4'd3, 4'd1, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd7, 4'd8, 4'd6, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd1, 4'd1, 4'd2, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_01_01; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL fwd_wb: got %b want %b", ctl(), exp); end
        tick();
        // ADD r1 ; ADD r1 ; ADD r2,r1,r9 -> M wins over W
        drain();
        applyStimulus(4'd2, 4'd3, 4'd1, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd2, 4'd3, 4'd1, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd1, 4'd9, 4'd2, 1, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_10_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL fwd_prio: got %b want %b", ctl(), exp); end
        tick();
    endtask

    task automatic test_load_use();
        // LDR r4 ; SUB r5,r4,r0
        drain();
        applyStimulus(4'd6, 4'd6, 4'd4, 1, 1, 0, 0, 0, 1); tick();
        applyStimulus(4'd4, 4'd0, 4'd5, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b1100_01_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL ldr_stall: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd4, 4'd0, 4'd5, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL ldr_one_bubble: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_01_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL ldr_fwd_wb: got %b want %b", ctl(), exp); end
        tick();
        // dependency through the second source
        drain();
        applyStimulus(4'd6, 4'd6, 4'd4, 1, 1, 0, 0, 0, 1); tick();
        applyStimulus(4'd0, 4'd4, 4'd5, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b1100_01_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL ldr_stall_rb: got %b want %b", ctl(), exp); end
        tick();
    endtask

    task automatic test_branch();
        drain();
        applyStimulus(4'd6, 4'd6, 4'd4, 1, 1, 0, 0, 0, 1); tick();
        applyStimulus(4'd4, 4'd0, 4'd5, 1, 0, 0, 0, 1, 1); #1;
        exp = 10'b1000_11_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL br_over_ldr: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1); #1;
        exp = 10'b0000_11_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL br_only: got %b want %b", ctl(), exp); end
        tick();
    endtask

    task automatic test_mem_wait();
        drain();
        applyStimulus(4'd6, 4'd6, 4'd4, 1, 1, 0, 0, 0, 1); tick();
        // not-ready with no memory op in M must not freeze
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0); #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL rdy_low_no_mem: got %b want %b", ctl(), exp); end
        tick();
        // load in M, ready low for three cycles then high: four frozen cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'd4, 4'd0, 4'd9, 1, 0, 0, 0, (i == 1), (i == 3)); #1;
            exp = 10'b1111_00_00_00; total++;
            if (ctl() !== exp) begin bad++; $display("[TB] FAIL freeze_cycle%0d: got %b want %b", i, ctl(), exp); end
            tick();
        end
        applyStimulus(4'd4, 4'd0, 4'd9, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL run_after_release: got %b want %b", ctl(), exp); end
        tick();
        // load must still have been in M at release, so it is in W now
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_01_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL mtag_held: got %b want %b", ctl(), exp); end
        tick();
    endtask

    task automatic test_pc_write();
        drain();
        applyStimulus(4'd0, 4'd0, 4'd15, 1, 0, 0, 1, 0, 1); #1;
        exp = 10'b1000_10_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL pc_in_d: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd15, 4'd15, 4'd3, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b1000_10_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL pc_in_e: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd15, 4'd15, 4'd3, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b1000_10_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL pc_in_m: got %b want %b", ctl(), exp); end
        tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL pc_resume: got %b want %b", ctl(), exp); end
        tick();
        // load to r15 followed by a reader of r15: no load-use stall
        drain();
        applyStimulus(4'd0, 4'd0, 4'd15, 1, 1, 0, 0, 0, 1); tick();
        applyStimulus(4'd15, 4'd15, 4'd3, 1, 0, 0, 0, 0, 1); #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL ldr_pc_guard: got %b want %b", ctl(), exp); end
        tick();
    endtask

    task automatic test_reset_mwait();
        drain();
        applyStimulus(4'd6, 4'd6, 4'd4, 1, 1, 0, 0, 0, 1); tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1); tick();
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0); tick();
        #1;
        exp = 10'b1111_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL mwait_before_rst: got %b want %b", ctl(), exp); end
        reset = 1'b1;
        #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL rst_in_mwait: got %b want %b", ctl(), exp); end
        tick();
        reset = 1'b0;
        #1;
        exp = 10'b0000_00_00_00; total++;
        if (ctl() !== exp) begin bad++; $display("[TB] FAIL run_after_rst: got %b want %b", ctl(), exp); end
`ifdef HAZ_PERF_CNT_EN
        total++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== 96'd0) begin
            bad++; $display("[TB] FAIL rst_mwait_counters: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
        end
`endif
        applyStimulus(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        $display("[TB] starting pipe_hazard_ctrl directed tests");
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_pc_write();
        test_reset_mwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline (F/D/E/M/W).
- Keeps its own shadow copy of the destination-tag pipeline from E through W.
- Generates stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipe registers.
- Includes a small FSM that freezes the pipeline while data memory is busy.
- Sits beside the datapath; its stall and flush outputs drive the enable and clear inputs of every pipe register.

Parameters:
REG_AW, 4, register address width
PC_REG, 15, register index of the PC (never forwarded, never a load-use source)

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high
RA1D  in  REG_AW  decode source register 1
RA2D  in  REG_AW  decode source register 2
WA3D  in  REG_AW  decode destination register
regWriteD  in  1  decode instruction writes the register file
MemtoRegD  in  1  decode instruction is a load
MemWriteD  in  1  decode instruction is a store
PCSrcD  in  1  decode instruction writes the PC through the register file
BranchTakenE  in  1  branch resolved as taken in E
dmem_ready  in  1  data memory completes the access this cycle
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register
ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  SrcB select, same encoding

Behaviour:
Shadow stage tags:
- Stages E, M, W each hold {valid, wa3, regWrite, memtoReg, memWrite, pcSrc, ra1, ra2}. ra1/ra2 are kept in E only.
- Reset clears all tags: valid=0, all other fields 0.
- Tags advance D->E->M->W on every cycle in which the pipeline is not frozen.
- FlushE loads E with valid=0 and all other fields 0.

Forwarding (combinational from the registered tags):
- ForwardAE=10 if valid_M & regWrite_M & wa3_M==ra1_E & ra1_E!=PC_REG.
- Else 01 if the same condition holds with W.
- Else 00. M wins when M and W both match.
- ForwardBE is identical, using ra2_E.

Load-use stall:
- ldrStall = valid_E & memtoReg_E & regWrite_E & (wa3_E==RA1D | wa3_E==RA2D), evaluated only for addresses != PC_REG.
- On ldrStall: StallF=1, StallD=1, FlushE=1 (one bubble inserted).

PC-write hazard:
- pcPend = PCSrcD | (valid_E&pcSrc_E) | (valid_M&pcSrc_M).
- On pcPend: StallF=1, FlushD=1.
- Then W writes the PC, and fetch resumes the following cycle.

Branch:
- BranchTakenE forces FlushD=1 and FlushE=1.
- Branch flush has priority over ldrStall: StallD=0 when both are asserted.

Memory FSM (states RUN, MWAIT):
- RUN -> MWAIT when valid_M & (memtoReg_M|memWrite_M) & !dmem_ready.
- MWAIT -> RUN on the first cycle dmem_ready=1.
- In MWAIT, and in the RUN cycle that enters it: StallF, StallD, StallE and StallM are all 1; Flush* are forced to 0; tags do not advance.
- In that frozen window, ldrStall and BranchTakenE are masked. They re-evaluate after the release.
- The release cycle behaves as a normal RUN cycle.

General rules:
- In reset, or the cycle after reset: all outputs are 0, FSM=RUN.
- Reset asserted during MWAIT returns the FSM to RUN with tags cleared.
- No output depends on dmem_ready except through the freeze condition.
- Latency: all controls are combinational on the current tags and D inputs; tags update at the clock edge.

Optional Feature:
HAZ_PERF_CNT_EN
- Enabled: adds outputs stall_cnt[31:0], flush_cnt[31:0], memwait_cnt[31:0].
  - stall_cnt counts ldrStall cycles.
  - flush_cnt counts BranchTakenE flushes.
  - memwait_cnt counts frozen cycles.
  - All three reset to 0 and saturate at all-ones (no wrap).
- Disabled: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
Package hazard_pkg:
- fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- mem_state_t enum: RUN, MWAIT.
- stage_tag_t packed struct holding the tag fields.
- Constant PC_REG_IDX.

Sub-module hazard_fwd_unit:
- Purely combinational ForwardAE/ForwardBE from the M/W tags and ra1/ra2 of E.
- Instantiated once.

Test Plan:
1. ADD r1 then ADD r2,r1,r3 -> next cycle ForwardAE=10. With a single independent instruction between them -> ForwardAE=01.
2. LDR r4 then SUB r5,r4,r0 -> StallF=StallD=FlushE=1 for exactly one cycle, then ForwardAE=01.
3. BranchTakenE=1 while ldrStall is also true -> FlushD=FlushE=1, StallD=0.
4. Load reaches M with dmem_ready held low 3 cycles -> all Stall*=1 for 4 cycles; the M tag is unchanged; Flush*=0 throughout.
5. Instruction with PCSrcD=1 -> StallF=1, FlushD=1 for 3 consecutive cycles (D, E, M), then normal fetch. Any instruction with wa3=15 never sets Forward*.
6. Reset asserted while in MWAIT -> next cycle FSM=RUN, all outputs 0. With HAZ_PERF_CNT_EN, the counters read 0.
